// File: rtl/irq_sched.sv
// irq_sched: three-source interrupt scheduler with one-deep pending buffers,
// round-robin grant, timeout re-arm pulse and an enforced low gap between posts.
module irq_sched #(
    parameter int unsigned TIMEOUT_CYCLES = 50000,
    parameter int unsigned GAP_CYCLES     = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_tx_irq,
    input  logic [63:0] i_tx_msg,
    input  logic        i_rx_irq,
    input  logic [63:0] i_rx_msg,
    input  logic        i_loss_irq,
    input  logic [63:0] i_loss_msg,
    input  logic        i_ack,
    input  logic        i_ovf_clr,
    output logic        o_irq,
    output logic [63:0] o_irq_msg,
    output logic [1:0]  o_irq_src,
    output logic [2:0]  o_overflow
);
    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0] GapLast = 8'(GAP_CYCLES - 1);

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StPost  = 2'd1;
    localparam logic [1:0] StRearm = 2'd2;
    localparam logic [1:0] StGap   = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [7:0]       gap_q, gap_d;
    logic [1:0]       last_q, last_d;
    logic [2:0]       pend_q, pend_d;
    logic [2:0][63:0] msg_q, msg_d;
    logic [63:0]      out_msg_q, out_msg_d;
    logic [1:0]       src_q, src_d;
    logic [2:0]       ovf_q, ovf_d;

    logic [2:0]       ev;
    logic [2:0][63:0] ev_msg;
    logic [2:0]       grant_clr;
    logic [2:0]       drop;
    logic             grant_valid;
    logic [1:0]       grant_idx;
    logic [2:0]       cand_sum;
    logic [1:0]       cand;

    assign ev     = {i_loss_irq, i_rx_irq, i_tx_irq};
    assign ev_msg = {i_loss_msg, i_rx_msg, i_tx_msg};

    // Walk the ring backwards so the source right after last_q ends up winning.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = 2'd0;
        cand_sum    = 3'd0;
        cand        = 2'd0;
        for (int k = 3; k >= 1; k--) begin
            cand_sum = {1'b0, last_q} + 3'(k);
            cand     = (cand_sum >= 3'd3) ? 2'(cand_sum - 3'd3) : cand_sum[1:0];
            if (pend_q[cand]) begin
                grant_valid = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        gap_d     = gap_q;
        last_d    = last_q;
        src_d     = src_q;
        out_msg_d = out_msg_q;
        grant_clr = 3'b000;
        case (state_q)
            StIdle: begin
                if (grant_valid) begin
                    grant_clr[grant_idx] = 1'b1;
                    last_d    = grant_idx;
                    src_d     = grant_idx + 2'd1;
                    out_msg_d = msg_q[grant_idx];
                    cnt_d     = '0;
                    state_d   = StPost;
                end
            end
            StPost: begin
                cnt_d = cnt_q + 1'b1;
                if (i_ack) begin
                    gap_d   = 8'd0;
                    state_d = StGap;
                end else if (cnt_q == CntLast) begin
                    state_d = StRearm;
                end
            end
            StRearm: begin
                cnt_d = '0;
                if (i_ack) begin
                    gap_d   = 8'd0;
                    state_d = StGap;
                end else begin
                    state_d = StPost;
                end
            end
            StGap: begin
                if (gap_q == GapLast) begin
                    state_d = StIdle;
                end else begin
                    gap_d = gap_q + 8'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // A grant frees its buffer this cycle, so a coincident event refills it without loss.
    always_comb begin
        pend_d = pend_q;
        msg_d  = msg_q;
        drop   = 3'b000;
        for (int s = 0; s < 3; s++) begin
            if (grant_clr[s]) begin
                pend_d[s] = 1'b0;
            end
            if (ev[s]) begin
                if (pend_q[s] && !grant_clr[s]) begin
                    drop[s] = 1'b1;
                end else begin
                    pend_d[s] = 1'b1;
                    msg_d[s]  = ev_msg[s];
                end
            end
        end
        ovf_d = (i_ovf_clr ? 3'b000 : ovf_q) | drop;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            gap_q     <= 8'd0;
            last_q    <= 2'd2;
            pend_q    <= 3'b000;
            msg_q     <= '0;
            out_msg_q <= 64'd0;
            src_q     <= 2'd0;
            ovf_q     <= 3'b000;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            gap_q     <= gap_d;
            last_q    <= last_d;
            pend_q    <= pend_d;
            msg_q     <= msg_d;
            out_msg_q <= out_msg_d;
            src_q     <= src_d;
            ovf_q     <= ovf_d;
        end
    end

    assign o_irq      = (state_q == StPost);
    assign o_irq_msg  = out_msg_q;
    assign o_irq_src  = src_q;
    assign o_overflow = ovf_q;
endmodule

// File: tb/tb_irq_sched.sv
// Bench for irq_sched: directed scenarios then random traffic, all checked
// every cycle against a timer-based behavioural model of the scheduler.
module tb_irq_sched;
    localparam int T = 8;
    localparam int G = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_tx_irq = 1'b0, i_rx_irq = 1'b0, i_loss_irq = 1'b0;
    logic [63:0] i_tx_msg = 64'd0, i_rx_msg = 64'd0, i_loss_msg = 64'd0;
    logic        i_ack = 1'b0, i_ovf_clr = 1'b0;
    logic        o_irq;
    logic [63:0] o_irq_msg;
    logic [1:0]  o_irq_src;
    logic [2:0]  o_overflow;

    int n_cmp = 0;
    int n_fail = 0;

    irq_sched #(.TIMEOUT_CYCLES(T), .GAP_CYCLES(G)) dut (
        .clk(clk), .rst(rst),
        .i_tx_irq(i_tx_irq), .i_tx_msg(i_tx_msg),
        .i_rx_irq(i_rx_irq), .i_rx_msg(i_rx_msg),
        .i_loss_irq(i_loss_irq), .i_loss_msg(i_loss_msg),
        .i_ack(i_ack), .i_ovf_clr(i_ovf_clr),
        .o_irq(o_irq), .o_irq_msg(o_irq_msg), .o_irq_src(o_irq_src),
        .o_overflow(o_overflow)
    );

    always #5 clk = ~clk;

    // Model: an outstanding interrupt toggles through a (T+1)-cycle period of
    // T high cycles and one low; after ack a countdown of G low cycles runs.
    bit          m_busy;
    int          m_age, m_gap, m_last;
    bit   [2:0]  m_pend;
    logic [63:0] m_msg [3];
    logic [63:0] m_out_msg;
    logic [1:0]  m_src;
    logic [2:0]  m_ovf;

    task automatic model_step();
        bit   [2:0]  old_pend;
        bit   [2:0]  ev;
        bit   [2:0]  drop;
        logic [63:0] msgin [3];
        int g;
        if (rst) begin
            m_busy = 0; m_age = 0; m_gap = 0; m_last = 2; m_pend = '0;
            for (int s = 0; s < 3; s++) m_msg[s] = '0;
            m_out_msg = '0; m_src = '0; m_ovf = '0;
            return;
        end
        ev = {i_loss_irq, i_rx_irq, i_tx_irq};
        msgin[0] = i_tx_msg; msgin[1] = i_rx_msg; msgin[2] = i_loss_msg;
        old_pend = m_pend;
        g = -1;
        if (!m_busy && m_gap == 0) begin
            for (int k = 1; k <= 3; k++) begin
                if (g < 0 && old_pend[(m_last + k) % 3]) g = (m_last + k) % 3;
            end
        end
        if (g >= 0) begin
            m_busy = 1; m_age = 0; m_last = g;
            m_out_msg = m_msg[g]; m_src = 2'(g + 1); m_pend[g] = 0;
        end else if (m_busy) begin
            if (i_ack) begin
                m_busy = 0; m_gap = G;
            end else begin
                m_age = (m_age + 1) % (T + 1);
            end
        end else if (m_gap > 0) begin
            m_gap--;
        end
        drop = '0;
        for (int s = 0; s < 3; s++) begin
            if (ev[s]) begin
                if (old_pend[s] && g != s) drop[s] = 1;
                else begin m_pend[s] = 1; m_msg[s] = msgin[s]; end
            end
        end
        m_ovf = (i_ovf_clr ? 3'b000 : m_ovf) | drop;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        #1;
        chk("irq", {63'd0, o_irq}, {63'd0, (m_busy && m_age != T)});
        chk("src", {62'd0, o_irq_src}, {62'd0, m_src});
        chk("msg", o_irq_msg, m_out_msg);
        chk("ovf", {61'd0, o_overflow}, {61'd0, m_ovf});
        i_tx_irq = 0; i_rx_irq = 0; i_loss_irq = 0; i_ack = 0; i_ovf_clr = 0;
    endtask

    task automatic do_reset();
        rst = 1; step(); rst = 0;
    endtask

    task automatic wait_irq(input string tag);
        int n = 0;
        while (o_irq !== 1'b1 && n < 20) begin step(); n++; end
        chk(tag, {63'd0, o_irq}, 64'd1);
    endtask

    initial begin
        // Reset values
        do_reset();
        chk("rst_irq", {63'd0, o_irq}, 64'd0);
        chk("rst_src", {62'd0, o_irq_src}, 64'd0);
        chk("rst_msg", o_irq_msg, 64'd0);
        chk("rst_ovf", {61'd0, o_overflow}, 64'd0);
        step();

        // RX event: latency 2, ack at N+5, low gap afterwards
        i_rx_irq = 1; i_rx_msg = 64'h2000_0000_0003_0366;
        step();
        chk("lat_n1", {63'd0, o_irq}, 64'd0);
        step();
        chk("lat_n2", {63'd0, o_irq}, 64'd1);
        chk("lat_src", {62'd0, o_irq_src}, 64'd2);
        chk("lat_msg", o_irq_msg, 64'h2000_0000_0003_0366);
        step(); step(); step();
        i_ack = 1;
        step();
        chk("ack_low", {63'd0, o_irq}, 64'd0);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("gap_low", {63'd0, o_irq}, 64'd0);
        end

        // Simultaneous events: round robin from TX after reset
        do_reset();
        i_tx_irq = 1; i_tx_msg = 64'h11; i_rx_irq = 1; i_rx_msg = 64'h22;
        i_loss_irq = 1; i_loss_msg = 64'h33;
        step();
        for (int i = 0; i < 3; i++) begin
            wait_irq("rr_wait");
            chk("rr_src", {62'd0, o_irq_src}, 64'(i + 1));
            i_ack = 1;
            step();
        end
        chk("rr_ovf", {61'd0, o_overflow}, 64'd0);

        // Loss overflow while posted with buffer full
        do_reset();
        i_loss_irq = 1; i_loss_msg = 64'hA;
        step();
        wait_irq("ovf_wait1");
        i_loss_irq = 1; i_loss_msg = 64'hB; step();
        i_loss_irq = 1; i_loss_msg = 64'hC; step();
        chk("ovf_set", {61'd0, o_overflow}, 64'd4);
        i_ack = 1; step();
        wait_irq("ovf_wait2");
        chk("ovf_keep", o_irq_msg, 64'hB);
        i_ovf_clr = 1; step();
        chk("ovf_clr", {61'd0, o_overflow}, 64'd0);
        i_ack = 1; step();

        // Timeout re-arm, then ack during the low cycle
        do_reset();
        i_tx_irq = 1; i_tx_msg = 64'h55; step();
        wait_irq("to_wait");
        for (int i = 0; i < T; i++) begin
            chk("to_high", {63'd0, o_irq}, 64'd1);
            step();
        end
        chk("to_low", {63'd0, o_irq}, 64'd0);
        step();
        chk("to_rehigh", {63'd0, o_irq}, 64'd1);
        repeat (T) step();
        chk("to_low2", {63'd0, o_irq}, 64'd0);
        i_ack = 1; step();
        for (int i = 0; i < 6; i++) begin
            chk("to_gap", {63'd0, o_irq}, 64'd0);
            step();
        end

        // Reset mid-POST with TX pending and a coincident event
        do_reset();
        i_tx_irq = 1; i_tx_msg = 64'h77; step();
        wait_irq("rp_wait");
        i_tx_irq = 1; i_tx_msg = 64'h78; step();
        step(); step();
        rst = 1; i_rx_irq = 1; i_rx_msg = 64'h99;
        step();
        rst = 0;
        chk("rp_irq", {63'd0, o_irq}, 64'd0);
        chk("rp_src", {62'd0, o_irq_src}, 64'd0);
        chk("rp_msg", o_irq_msg, 64'd0);
        for (int i = 0; i < 10; i++) begin
            step();
            chk("rp_quiet", {63'd0, o_irq}, 64'd0);
        end

        // TX event coincident with its own grant
        do_reset();
        i_tx_irq = 1; i_tx_msg = 64'hAAAA; step();
        i_tx_irq = 1; i_tx_msg = 64'hBBBB; step();
        chk("cg_first", o_irq_msg, 64'hAAAA);
        i_ack = 1; step();
        wait_irq("cg_wait");
        chk("cg_second", o_irq_msg, 64'hBBBB);
        chk("cg_ovf", {61'd0, o_overflow}, 64'd0);
        i_ack = 1; step();

        // Random traffic
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            i_tx_irq   = ($urandom_range(7) == 0);
            i_rx_irq   = ($urandom_range(7) == 0);
            i_loss_irq = ($urandom_range(9) == 0);
            i_tx_msg   = {$urandom, $urandom};
            i_rx_msg   = {$urandom, $urandom};
            i_loss_msg = {$urandom, $urandom};
            i_ack      = ($urandom_range(5) == 0);
            i_ovf_clr  = ($urandom_range(39) == 0);
            rst        = ($urandom_range(399) == 0);
            step();
        end
        rst = 0;
        repeat (5) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/irq_sched.md
IRQ_SCHED -- requirements
Module: irq_sched

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 50000: cycles o_irq stays high without i_ack before a re-arm pulse.
REQ-002 SHALL have parameter GAP_CYCLES, default 4: minimum o_irq low cycles between two posted interrupts; legal range 1..255.
REQ-003 SHALL use a single clock and a synchronous, active-high reset: clk, input, 1 bit, sole clock; rst, input, 1 bit, synchronous active-high reset.
REQ-004 i_tx_irq  in  1: TX-done event, one-cycle pulse.
REQ-005 i_tx_msg  in  64: TX status word, valid with i_tx_irq.
REQ-006 i_rx_irq  in  1: RX-frame event, one-cycle pulse.
REQ-007 i_rx_msg  in  64: RX status word, valid with i_rx_irq.
REQ-008 i_loss_irq  in  1: sync/link-loss event, one-cycle pulse.
REQ-009 i_loss_msg  in  64: loss status word, valid with i_loss_irq.
REQ-010 i_ack  in  1: CPU read of IRQ status register, one-cycle pulse.
REQ-011 i_ovf_clr  in  1: clears o_overflow, one-cycle pulse.
REQ-012 o_irq  out  1: level interrupt to PS.
REQ-013 o_irq_msg  out  64: status word of the posted interrupt.
REQ-014 o_irq_src  out  2: posted source; 1=TX, 2=RX, 3=loss, 0=none.
REQ-015 o_overflow  out  3: sticky drop flags; bit0 TX, bit1 RX, bit2 loss.

Function
REQ-016 Each source SHALL have a one-deep pending buffer (flag + 64-bit msg), loaded at the clock edge ending the event cycle.
REQ-017 Event while that source's pending flag is already set: stored msg SHALL be kept, new msg dropped, matching o_overflow bit set.
REQ-018 Event in the same cycle the grant clears that source's pending flag: flag SHALL stay set with the new msg; no overflow.
REQ-019 Simultaneous events on different sources SHALL each load their own buffer independently.
REQ-020 Arbitration SHALL be round-robin over TX, RX, loss, starting after the last granted source; after reset the order is TX, RX, loss.
REQ-021 FSM states: IDLE, POST, REARM, GAP.
REQ-022 IDLE: if any pending flag is set, grant per REQ-020, clear the granted flag, load o_irq_msg/o_irq_src, go POST; else stay.
REQ-023 POST: o_irq=1; the timeout counter increments each cycle.
REQ-024 POST with i_ack: o_irq=0 next cycle, go GAP.
REQ-025 POST, counter reaching TIMEOUT_CYCLES-1 with no i_ack: go REARM.
REQ-026 REARM: o_irq=0 for exactly 1 cycle, counter cleared, return to POST; i_ack in REARM goes to GAP.
REQ-027 GAP: o_irq=0 for GAP_CYCLES cycles, then IDLE.
REQ-028 o_irq_msg and o_irq_src SHALL hold their value through POST/REARM/GAP and update only on a new grant.
REQ-029 i_ack in IDLE or GAP SHALL be ignored.
REQ-030 Latency: event in cycle N with FSM in IDLE and no other pending SHALL give o_irq=1 in cycle N+2.
REQ-031 i_ovf_clr SHALL clear all o_overflow bits; an overflow in the same cycle SHALL win (its bit set).
REQ-032 Timeout counter SHALL be wide enough for TIMEOUT_CYCLES, saturate-free, and clear on entering POST from IDLE.

Reset
REQ-033 rst SHALL force: FSM IDLE, o_irq=0, o_irq_msg=0, o_irq_src=0, o_overflow=0, all pending flags clear, counters 0, round-robin to TX-first.
REQ-034 rst during POST/REARM/GAP SHALL drop o_irq the next cycle and discard all pending events; events coincident with rst SHALL be lost.

Verification
REQ-035 i_rx_irq, i_rx_msg=64'h2000_0000_0003_0366 at N -> o_irq=1 at N+2, o_irq_src=2, msg matches; i_ack at N+5 -> o_irq=0 at N+6, low at least 4 cycles.
REQ-036 TX, RX, loss pulsed in the same cycle after reset -> grants in order TX, RX, loss; each cleared by i_ack; three o_irq pulses; o_overflow=0.
REQ-037 Two i_loss_irq pulses while the loss interrupt is posted and the loss buffer already holds one -> o_overflow=3'b100, first buffered msg delivered; i_ovf_clr -> 0.
REQ-038 TIMEOUT_CYCLES=8, no i_ack -> o_irq high 8 cycles, low 1, high again, repeating; i_ack during the low cycle -> GAP entered.
REQ-039 rst asserted 3 cycles into POST with TX pending -> o_irq=0 next cycle, all outputs 0; no interrupt after rst release.
REQ-040 i_tx_irq in the same cycle its earlier pending TX is granted -> second TX posted after GAP with the new msg; o_overflow=0.
